// File: rtl/rx_decode_pkg.sv
`default_nettype none
// ============================================================================
// rx_decode_pkg : frame type codes, 3-of-6 code table and checksum helper
// Rev 1.0
// ============================================================================
package rx_decode_pkg;

   localparam logic [2:0] TYPE_TOKEN     = 3'd0;
   localparam logic [2:0] TYPE_ACK       = 3'd1;
   localparam logic [2:0] TYPE_NACK      = 3'd2;
   localparam logic [2:0] TYPE_DATA_CSUM = 3'd3;
   localparam logic [2:0] TYPE_DATA_3OF6 = 3'd4;

   // Indexed by the 3-bit value; entry v is the 6-bit code for v.
   localparam logic [7:0][5:0] SYM3OF6_ENC = {
      6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07
   };

   // Adds the three nibbles of a 12-bit chunk into a running mod-16 sum.
   function automatic logic [3:0] csum_add12(input logic [3:0]  acc,
                                             input logic [11:0] chunk);
      return acc + chunk[3:0] + chunk[7:4] + chunk[11:8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/sym3of6_dec.sv
`default_nettype none
// ============================================================================
// sym3of6_dec : combinational 3-of-6 symbol decoder (invalid code -> 000, err)
// Rev 1.0
// ============================================================================
module sym3of6_dec
   import rx_decode_pkg::*;
(
   input  logic [5:0] code,
   output logic [2:0] value,
   output logic       err
);

   always_comb begin
      value = 3'd0;
      err   = 1'b1;
      for (int v = 0; v < 8; v++) begin
         if (code == SYM3OF6_ENC[v]) begin
            value = 3'(v);
            err   = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rx_decode_pipe.sv
`default_nettype none
// ============================================================================
// rx_decode_pipe : two-stage RX frame decoder (checksum / 3-of-6 payloads)
// Rev 1.0
// ============================================================================
module rx_decode_pipe
   import rx_decode_pkg::*;
#(
   parameter  int PAYLOAD_W = 24,
   parameter  int ADDR_W    = 4,
   parameter  int CNT_W     = 8,
   localparam int TYPE_W    = 3,
   localparam int RAW_W     = 2*PAYLOAD_W,
   localparam int FRAME_W   = TYPE_W + ADDR_W + RAW_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FRAME_W-1:0]   in_frame,
   input  logic [ADDR_W-1:0]    node_addr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [TYPE_W-1:0]    out_type,
   output logic [ADDR_W-1:0]    out_addr,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic                 out_bad,
   output logic                 out_for_me,
   output logic [CNT_W-1:0]     err_cnt,
   input  logic                 err_cnt_clr
);

   localparam int NSYM   = PAYLOAD_W / 3;
   localparam int NCHUNK = PAYLOAD_W / 12;

   if (PAYLOAD_W % 12 != 0) begin : g_width_check
      $error("rx_decode_pipe: PAYLOAD_W must be a multiple of 12");
   end

   logic [TYPE_W-1:0]    f_type;
   logic [ADDR_W-1:0]    f_addr;
   logic [RAW_W-1:0]     f_raw;
   logic [PAYLOAD_W-1:0] sym_val;
   logic [NSYM-1:0]      sym_err;

   assign f_type = in_frame[FRAME_W-1 -: TYPE_W];
   assign f_addr = in_frame[RAW_W +: ADDR_W];
   assign f_raw  = in_frame[RAW_W-1:0];

   for (genvar i = 0; i < NSYM; i++) begin : g_sym
      sym3of6_dec u_dec (
         .code  (f_raw[6*i +: 6]),
         .value (sym_val[3*i +: 3]),
         .err   (sym_err[i])
      );
   end

   // Stage registers
   logic                 s1_valid;
   logic [TYPE_W-1:0]    s1_type;
   logic [ADDR_W-1:0]    s1_addr;
   logic [PAYLOAD_W-1:0] s1_sym_val;
   logic [NSYM-1:0]      s1_sym_err;
   logic [PAYLOAD_W-1:0] s1_csum_pay;
   logic [3:0]           s1_csum_fld;

   logic                 s2_valid;
   logic [TYPE_W-1:0]    s2_type;
   logic [ADDR_W-1:0]    s2_addr;
   logic [PAYLOAD_W-1:0] s2_payload;
   logic                 s2_bad;
   logic                 s2_for_me;
   logic [CNT_W-1:0]     cnt_q;

   logic s2_adv;
   logic s1_adv;

   assign s2_adv   = ~s2_valid | out_ready;
   assign s1_adv   = ~s1_valid | s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_type     <= '0;
         s1_addr     <= '0;
         s1_sym_val  <= '0;
         s1_sym_err  <= '0;
         s1_csum_pay <= '0;
         s1_csum_fld <= '0;
      end else if (s1_adv) begin
         s1_valid    <= in_valid;
         s1_type     <= f_type;
         s1_addr     <= f_addr;
         s1_sym_val  <= sym_val;
         s1_sym_err  <= sym_err;
         s1_csum_pay <= f_raw[RAW_W-1 -: PAYLOAD_W];
         s1_csum_fld <= f_raw[PAYLOAD_W-1 -: 4];
      end
   end

   logic [3:0]           csum;
   logic [PAYLOAD_W-1:0] nxt_payload;
   logic                 nxt_bad;

   // Reserved types fall through to the defaults: zero payload, flagged bad.
   always_comb begin
      csum = 4'd0;
      for (int c = 0; c < NCHUNK; c++) begin
         csum = csum_add12(csum, s1_csum_pay[12*c +: 12]);
      end
      nxt_payload = '0;
      nxt_bad     = 1'b1;
      case (s1_type)
         TYPE_TOKEN, TYPE_ACK, TYPE_NACK: begin
            nxt_bad = 1'b0;
         end
         TYPE_DATA_CSUM: begin
            nxt_payload = s1_csum_pay;
            nxt_bad     = (s1_csum_fld != csum);
         end
         TYPE_DATA_3OF6: begin
            nxt_payload = s1_sym_val;
            nxt_bad     = |s1_sym_err;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         s2_type    <= '0;
         s2_addr    <= '0;
         s2_payload <= '0;
         s2_bad     <= 1'b0;
         s2_for_me  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid   <= s1_valid;
         s2_type    <= s1_type;
         s2_addr    <= s1_addr;
         s2_payload <= nxt_payload;
         s2_bad     <= nxt_bad;
         s2_for_me  <= (s1_addr == node_addr) | (&s1_addr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (err_cnt_clr) begin
         cnt_q <= '0;
      end else if (s2_valid && out_ready && s2_bad && (cnt_q != '1)) begin
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign out_valid   = s2_valid;
   assign out_type    = s2_type;
   assign out_addr    = s2_addr;
   assign out_payload = s2_payload;
   assign out_bad     = s2_bad;
   assign out_for_me  = s2_for_me;
   assign err_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: doc/rx_decode_pipe.md
Name: rx_decode_pipe

Overview:
Parametrised, pipelined successor to the router's receive-side frame decoder. It accepts one serialized RX frame per cycle over a valid/ready handshake and splits it into type, address and raw fields. It decodes the payload with either the nibble-checksum code or the 3-of-6 code, selected by frame type, and flags decode errors for the selected code only. It also flags frames addressed to this node, keeps a saturating error counter, and sits between the RX deserializer and the node interface.

Parameters:
PAYLOAD_W, 24, decoded payload width; must be a multiple of 12
ADDR_W, 4, node address width
CNT_W, 8, error counter width
TYPE_W, 3, fixed, frame type field width
RAW_W, 2*PAYLOAD_W, derived, raw payload field width
FRAME_W, TYPE_W+ADDR_W+RAW_W, derived; 55 at defaults

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  in_frame is valid
in_ready  out  1  block accepts in_frame this cycle
in_frame  in  FRAME_W  {type, addr, raw}, MSB first
node_addr  in  ADDR_W  this node's address; quasi-static
out_valid  out  1  output bundle is valid
out_ready  in  1  consumer accepts the output bundle
out_type  out  TYPE_W  frame type
out_addr  out  ADDR_W  frame address
out_payload  out  PAYLOAD_W  decoded payload
out_bad  out  1  decode error or reserved type
out_for_me  out  1  out_addr equals node_addr, or out_addr is all-ones (broadcast)
err_cnt  out  CNT_W  count of bad frames accepted at the output
err_cnt_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Reset: all valid bits, data registers and err_cnt go to 0. Every output reads 0 except in_ready, which reads 1 from the first cycle after reset release. A reset mid-flight discards in-flight frames with no output.
- Pipeline stages:
  - S1 registers the type and address fields, the 3-of-6 decode of each symbol with per-symbol error bits, and the checksum-mode payload and checksum fields.
  - S2 computes and compares the checksum, selects the payload and error by type, and drives the outputs.
- Timing: latency 2 cycles from the input handshake to out_valid. Throughput is 1 frame per cycle while out_ready=1.
- Handshake:
  - Each stage advances when it is empty or its downstream accepts.
  - in_ready = ~s1_valid | (~s2_valid | out_ready).
  - The output bundle stays stable while out_valid=1 and out_ready=0.
  - No frame is lost or reordered.
- Frame layout: type = in_frame[FRAME_W-1 -: 3], addr = next ADDR_W bits, raw = the low RAW_W bits.
- Type codes:
  - 0 TOKEN, 1 ACK, 2 NACK: control frames; payload = 0, bad = 0, raw is ignored.
  - 3 DATA_CSUM: payload = raw[RAW_W-1 -: PAYLOAD_W]; checksum field = the next 4 bits below the payload; the remaining low bits are ignored. bad = checksum field != (sum of payload nibbles mod 16).
  - 4 DATA_3OF6: raw holds PAYLOAD_W/3 symbols; symbol i = raw[6i+5:6i] decodes to payload[3i+2:3i]. bad = OR of the per-symbol errors. An invalid symbol decodes to 000.
  - 5-7 are reserved: payload = 0, bad = 1.
- 3-of-6 code table (value -> code): 0->07, 1->0B, 2->0D, 3->0E, 4->13, 5->15, 6->16, 7->19 (hex). Any other 6-bit pattern is an error, including other weight-3 patterns.
- err_cnt:
  - Increments when out_valid & out_ready & out_bad.
  - Saturates at all-ones.
  - err_cnt_clr has priority; a clear in the same cycle as an increment yields 0.
- node_addr is sampled in S2.

Decomposition:
- Package rx_decode_pkg holds:
  - the type code localparams (TYPE_TOKEN to TYPE_DATA_3OF6);
  - the 3-of-6 encode table;
  - a function for the nibble checksum.
- One sub-module, sym3of6_dec: combinational; 6-bit code in, 3-bit value plus error out. Instantiated PAYLOAD_W/3 times via generate.
- Include an elaboration check that PAYLOAD_W % 12 == 0.

Test Plan:
- Good checksum frame: type 3, addr 5, payload 24'h123456, checksum 4'h5, low 20 bits 0, node_addr=5, out_ready=1 -> 2 cycles later out_payload=24'h123456, out_bad=0, out_for_me=1, err_cnt=0.
- Checksum error: same frame with checksum 4'h6 -> out_bad=1; err_cnt=1 after the handshake.
- 3-of-6 frames:
  - All symbols 6'h19 -> payload 24'hFFFFFF, bad=0.
  - Symbol 0 = 6'h3F -> bad=1, payload[2:0]=0.
  - Symbol 0 = 6'h1C (weight 3, not in the table) -> bad=1.
- Control and reserved types: TOKEN with random raw, addr=F, node_addr=2 -> payload=0, bad=0, for_me=1. Type 6 -> bad=1.
- Backpressure: stream 4 frames with out_ready=0 for 3 cycles:
  - in_ready drops once S1 and S2 are full.
  - The output holds stable.
  - After release, all 4 frames emerge in order with no duplicates.
- Counter and reset:
  - CNT_W=2 with 5 bad frames -> err_cnt=3.
  - err_cnt_clr in the same cycle as a bad accept -> 0.
  - Assert rst_n low with 2 frames in flight -> out_valid=0 immediately and no stale output after release.
